// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU width, op-select codes and arbiter state encoding.
package alu_pkg;
   localparam int ALU_W = 3;
   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_SUB = 2'b01;
   localparam logic [1:0] ALU_OP_AND = 2'b10;
   localparam logic [1:0] ALU_OP_OR  = 2'b11;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
endpackage

// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: request/operand/response bundle between two clients and the shared-ALU arbiter.
interface alu_share_arb_if;
   import alu_pkg::*;
   logic [1:0] req, gnt, rsp_valid, rsp_ready, sel0, sel1;
   logic [ALU_W-1:0] a0, b0, a1, b1, rsp_y;
   logic rsp_cout, busy;
   modport master(output req, a0, b0, sel0, a1, b1, sel1, rsp_ready,
                  input gnt, rsp_valid, rsp_y, rsp_cout, busy);
   modport slave(input req, a0, b0, sel0, a1, b1, sel1, rsp_ready,
                 output gnt, rsp_valid, rsp_y, rsp_cout, busy);
endinterface

// File: rtl/alu_top_3bit.sv
// alu_top_3bit: combinational 3-bit ALU; SUB carry is the no-borrow flag, logic ops clear carry.
module alu_top_3bit
   import alu_pkg::*;
(
   input  logic [ALU_W-1:0] a,
   input  logic [ALU_W-1:0] b,
   input  logic [1:0]       sel,
   output logic [ALU_W-1:0] y,
   output logic             cout
);
   logic [ALU_W:0] r;
   always_comb begin
      r = sel == ALU_OP_ADD ? {1'b0, a} + {1'b0, b} :
          sel == ALU_OP_SUB ? {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, 1'b1} :
          sel == ALU_OP_AND ? {1'b0, a & b} : {1'b0, a | b};
   end
   assign {cout, y} = r;
endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter sequencing two requesters onto one alu_top_3bit
// through latch / execute / respond steps.
module alu_share_arb
   import alu_pkg::*;
#(
   parameter bit RR_RESET_PTR = 1'b1
) (
   input logic            clk,
   input logic            rst,
   alu_share_arb_if.slave bus
);
   arb_state_t state, next;
   logic last, id, win, grant, alu_c, c_q;
   logic [ALU_W-1:0] op_a, op_b, alu_y, y_q;
   logic [1:0] op_sel;
   // on a tie the requester that did not win last time goes next
   always_comb begin
      win = bus.req == 2'b11 ? ~last : bus.req[1];
      grant = state == IDLE && |bus.req;
      next = state == IDLE ? (grant ? EXEC : IDLE) :
             state == EXEC ? RESP : (bus.rsp_ready[id] ? IDLE : RESP);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         last   <= RR_RESET_PTR;
         id     <= 1'b0;
         op_a   <= '0;
         op_b   <= '0;
         op_sel <= '0;
         y_q    <= '0;
         c_q    <= 1'b0;
      end else begin
         state <= next;
         if (grant) begin
            id     <= win;
            last   <= win;
            op_a   <= win ? bus.a1 : bus.a0;
            op_b   <= win ? bus.b1 : bus.b0;
            op_sel <= win ? bus.sel1 : bus.sel0;
         end
         if (state == EXEC) begin
            y_q <= alu_y;
            c_q <= alu_c;
         end
      end
   end
   alu_top_3bit u_alu (.a(op_a), .b(op_b), .sel(op_sel), .y(alu_y), .cout(alu_c));
   assign bus.gnt       = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign bus.rsp_valid = state == RESP ? (id ? 2'b10 : 2'b01) : 2'b00;
   assign bus.busy      = state != IDLE;
   assign bus.rsp_y     = y_q;
   assign bus.rsp_cout  = c_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: table vectors, directed corner sequences and randomized transactions
// checked against a transaction-level arithmetic model.
module tb_alu_share_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   logic last_m = 1'b1;
   alu_share_arb_if bus();
   alu_share_arb dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] req;
      logic [2:0] a0, b0;
      logic [1:0] s0;
      logic [2:0] a1, b1;
      logic [1:0] s1;
      logic [1:0] eg;
      logic [2:0] ey;
      logic       ec;
   } vec_t;

   vec_t tbl [7];

   function automatic logic [3:0] ref_alu(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
      int av = int'(a);
      int bv = int'(b);
      if (s == 2'd0) return 4'(av + bv);
      if (s == 2'd1) return {av >= bv, 3'(av - bv)};
      if (s == 2'd2) return {1'b0, a & b};
      return {1'b0, a | b};
   endfunction

   function automatic logic [1:0] model_gnt(input logic [1:0] r);
      if (r == 2'b00) return 2'b00;
      if (r == 2'b11) return last_m ? 2'b01 : 2'b10;
      return r;
   endfunction

   task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   // one full operation from a negedge in IDLE back to a negedge in IDLE
   task automatic run_txn(input vec_t v, input int stall, input logic [1:0] hold);
      bus.req = v.req;
      bus.a0 = v.a0; bus.b0 = v.b0; bus.sel0 = v.s0;
      bus.a1 = v.a1; bus.b1 = v.b1; bus.sel1 = v.s1;
      #1;
      chk("gnt", bus.gnt, v.eg);
      last_m = v.eg[1];
      @(posedge clk); @(negedge clk);
      bus.req = 2'b00;
      bus.a0 = 3'($urandom); bus.b0 = 3'($urandom); bus.sel0 = 2'($urandom);
      bus.a1 = 3'($urandom); bus.b1 = 3'($urandom); bus.sel1 = 2'($urandom);
      #1;
      chk("exec_busy", bus.busy, 1);
      chk("exec_gnt", bus.gnt, 0);
      chk("exec_valid", bus.rsp_valid, 0);
      @(posedge clk); @(negedge clk);
      chk("rsp_valid", bus.rsp_valid, v.eg);
      chk("rsp_y", bus.rsp_y, v.ey);
      chk("rsp_cout", bus.rsp_cout, v.ec);
      bus.req = hold;
      for (int k = 0; k < stall; k++) begin
         bus.rsp_ready = ~v.eg;
         @(posedge clk); @(negedge clk);
         #1;
         chk("bp_valid", bus.rsp_valid, v.eg);
         chk("bp_y", bus.rsp_y, v.ey);
         chk("bp_cout", bus.rsp_cout, v.ec);
         chk("bp_gnt", bus.gnt, 0);
         chk("bp_busy", bus.busy, 1);
      end
      bus.rsp_ready = v.eg;
      @(posedge clk); @(negedge clk);
      bus.rsp_ready = 2'b00;
      #1;
      chk("idle_valid", bus.rsp_valid, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_gnt", bus.gnt, model_gnt(hold));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      logic [3:0] res;
      logic w;
      tbl[0] = '{2'b01, 3'd3, 3'd2, 2'd0, 3'd0, 3'd0, 2'd0, 2'b01, 3'd5, 1'b0};
      tbl[1] = '{2'b10, 3'd0, 3'd0, 2'd0, 3'd7, 3'd1, 2'd0, 2'b10, 3'd0, 1'b1};
      tbl[2] = '{2'b11, 3'd4, 3'd5, 2'd0, 3'd1, 3'd1, 2'd0, 2'b01, 3'd1, 1'b1};
      tbl[3] = '{2'b11, 3'd1, 3'd1, 2'd0, 3'd6, 3'd2, 2'd1, 2'b10, 3'd4, 1'b1};
      tbl[4] = '{2'b11, 3'd2, 3'd5, 2'd1, 3'd3, 3'd3, 2'd0, 2'b01, 3'd5, 1'b0};
      tbl[5] = '{2'b10, 3'd0, 3'd0, 2'd0, 3'd6, 3'd3, 2'd2, 2'b10, 3'd2, 1'b0};
      tbl[6] = '{2'b01, 3'd5, 3'd2, 2'd3, 3'd0, 3'd0, 2'd0, 2'b01, 3'd7, 1'b0};
      bus.req = 2'b00; bus.rsp_ready = 2'b00;
      bus.a0 = 3'd0; bus.b0 = 3'd0; bus.sel0 = 2'd0;
      bus.a1 = 3'd0; bus.b1 = 3'd0; bus.sel1 = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_y", bus.rsp_y, 0);
      chk("rst_cout", bus.rsp_cout, 0);
      chk("rst_busy", bus.busy, 0);
      foreach (tbl[i]) run_txn(tbl[i], 0, 2'b00);
      // operand isolation: a0 is scrambled during EXEC inside run_txn
      run_txn('{2'b01, 3'd1, 3'd1, 2'd0, 3'd0, 3'd0, 2'd0, 2'b01, 3'd2, 1'b0}, 0, 2'b00);
      // backpressure with requester 1 waiting, then it is granted right away
      run_txn('{2'b01, 3'd5, 3'd6, 2'd0, 3'd3, 3'd3, 2'd0, 2'b01, 3'd3, 1'b1}, 5, 2'b10);
      run_txn('{2'b10, 3'd0, 3'd0, 2'd0, 3'd3, 3'd3, 2'd0, 2'b10, 3'd6, 1'b0}, 0, 2'b00);
      for (int i = 0; i < 40; i++) begin
         v.req = 2'($urandom_range(1, 3));
         v.a0 = 3'($urandom); v.b0 = 3'($urandom); v.s0 = 2'($urandom);
         v.a1 = 3'($urandom); v.b1 = 3'($urandom); v.s1 = 2'($urandom);
         w = v.req == 2'b11 ? ~last_m : v.req[1];
         v.eg = w ? 2'b10 : 2'b01;
         res = w ? ref_alu(v.a1, v.b1, v.s1) : ref_alu(v.a0, v.b0, v.s0);
         v.ey = res[2:0];
         v.ec = res[3];
         run_txn(v, $urandom_range(0, 3), 2'b00);
      end
      // tie after reset: grants alternate 01,10,01 three cycles apart
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      last_m = 1'b1;
      bus.req = 2'b11; bus.rsp_ready = 2'b11;
      bus.a0 = 3'd3; bus.b0 = 3'd2; bus.sel0 = 2'd0;
      bus.a1 = 3'd1; bus.b1 = 3'd1; bus.sel1 = 2'd0;
      for (int i = 0; i < 9; i++) begin
         #1;
         chk("tie_gnt", bus.gnt, i % 3 != 0 ? 2'b00 : ((i / 3) % 2 == 1 ? 2'b10 : 2'b01));
         if (i == 8) bus.req = 2'b00;
         @(posedge clk); @(negedge clk);
      end
      // reset in EXEC discards the operation
      bus.req = 2'b01; bus.a0 = 3'd3; bus.b0 = 3'd2; bus.sel0 = 2'd0;
      #1;
      chk("rx_gnt", bus.gnt, 2'b01);
      @(posedge clk); @(negedge clk);
      bus.req = 2'b00;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rx_valid", bus.rsp_valid, 0);
      chk("rx_busy", bus.busy, 0);
      chk("rx_y", bus.rsp_y, 0);
      chk("rx_cout", bus.rsp_cout, 0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); @(negedge clk);
         #1;
         chk("rx_no_rsp", bus.rsp_valid, 0);
      end
      bus.rsp_ready = 2'b00;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
